serializer_16: RTL and testbench



---
 rtl/serializer_16.sv | 145 ++++++++++++++
 tb/tb_serializer_16.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_16.sv
// ---------------------------------------------------------------------------
// serializer_16
// Parallel-to-serial front end for the programmable 1-bit delay line.
// Takes a parallel word plus a bit count over a valid/ready handshake and
// shifts it out MSB-first, one bit per clock. A one-word pending slot lets
// back-to-back words stream with no idle cycle between them.
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous active-high reset
//   data_i          parallel word, MSB transmitted first
//   data_mod_i      number of bits to send; 0 means DATA_W
//   data_val_i      word valid
//   ready_o         block can accept a word this cycle (combinational)
//   ser_data_o      serial bit, 0 whenever ser_data_val_o is 0
//   ser_data_val_o  ser_data_o carries a payload bit
//   busy_o          shift in progress or pending slot occupied
// ---------------------------------------------------------------------------
module serializer_16 #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ready_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    // One extra bit so a full word (DATA_W bits) fits in the count.
    localparam int CNT_W = MOD_W + 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [CNT_W-1:0]  remaining_q, remaining_n;
    logic [DATA_W-1:0] pend_data_q, pend_data_n;
    logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_n;
    logic              pend_full_q, pend_full_n;
    logic              ser_data_q, ser_val_q, busy_q;

    logic              accept;
    logic [CNT_W-1:0]  in_cnt;

    // The pending slot is the only thing that can refuse a word; reset also
    // holds ready low so nothing is accepted while the block is cleared.
    assign ready_o = ~pend_full_q & ~rst_i;
    assign accept  = data_val_i & ready_o;

    // A zero count field encodes a full-width word.
    assign in_cnt = (data_mod_i == '0) ? CNT_W'(DATA_W) : {1'b0, data_mod_i};

    // Next-state logic. The active register always presents its MSB as the
    // current bit; each edge in SHIFT consumes one bit. When the last bit
    // leaves, the next word (pending first, otherwise a same-edge accept) is
    // loaded straight into the active register so the stream has no gap.
    always_comb begin
        state_n     = state_q;
        shift_n     = shift_q;
        remaining_n = remaining_q;
        pend_data_n = pend_data_q;
        pend_cnt_n  = pend_cnt_q;
        pend_full_n = pend_full_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_n     = data_i;
                    remaining_n = in_cnt;
                    state_n     = SHIFT;
                end
            end
            SHIFT: begin
                if (remaining_q == CNT_W'(1)) begin
                    if (pend_full_q) begin
                        shift_n     = pend_data_q;
                        remaining_n = pend_cnt_q;
                        pend_full_n = 1'b0;
                    end else if (accept) begin
                        shift_n     = data_i;
                        remaining_n = in_cnt;
                    end else begin
                        shift_n     = '0;
                        remaining_n = '0;
                        state_n     = IDLE;
                    end
                end else begin
                    shift_n     = shift_q << 1;
                    remaining_n = remaining_q - CNT_W'(1);
                    if (accept) begin
                        pend_data_n = data_i;
                        pend_cnt_n  = in_cnt;
                        pend_full_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n     = IDLE;
                shift_n     = '0;
                remaining_n = '0;
            end
        endcase
    end

    // State and datapath registers. Reset discards the active word and the
    // pending slot so no partial word resumes after release. The serial
    // outputs are registered from the next-state values so they line up with
    // the contents of the active register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            remaining_q <= '0;
            pend_data_q <= '0;
            pend_cnt_q  <= '0;
            pend_full_q <= 1'b0;
            ser_data_q  <= 1'b0;
            ser_val_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            shift_q     <= shift_n;
            remaining_q <= remaining_n;
            pend_data_q <= pend_data_n;
            pend_cnt_q  <= pend_cnt_n;
            pend_full_q <= pend_full_n;
            ser_val_q   <= (remaining_n != '0);
            ser_data_q  <= (remaining_n != '0) & shift_n[DATA_W-1];
            busy_q      <= (remaining_n != '0) | pend_full_n;
        end
    end

    assign ser_data_o     = ser_data_q;
    assign ser_data_val_o = ser_val_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_serializer_16.sv
// ---------------------------------------------------------------------------
// tb_serializer_16
// Directed bench for serializer_16. Stimulus pushes the hand-computed bit
// stream (with the cycle each bit must appear in) into a scoreboard queue;
// a monitor pops and compares whenever ser_data_val_o is high. A second
// queue checks the stream after a 5-cycle delay line model fed by the DUT.
// ---------------------------------------------------------------------------
module tb_serializer_16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        data_val_i;
    logic        ready_o;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;

    typedef struct {
        logic b;
        int   cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t dl_q[$];

    int checks    = 0;
    int errors    = 0;
    int cycle_cnt = 0;
    int next_free = 0;

    logic [4:0] dl_data;
    logic [4:0] dl_val;

    serializer_16 dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .ready_o        (ready_o),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    // Free-running clock and an edge counter used to timestamp every bit.
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycle_cnt <= cycle_cnt + 1;

    // Five-stage delay line model; it shares the reset with the serializer.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dl_data <= '0;
            dl_val  <= '0;
        end else begin
            dl_data <= {dl_data[3:0], ser_data_o};
            dl_val  <= {dl_val[3:0], ser_data_val_o};
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d",
                     name, actual, expected, cycle_cnt);
        end
    endtask

    // Scoreboard monitor on the serializer output: every valid bit must be
    // the next expected bit, in exactly the expected cycle; idle bits are 0.
    always @(negedge clk_i) begin
        exp_t e;
        if (ser_data_val_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_bit: got bit %0b, expected none at cycle %0d",
                         ser_data_o, cycle_cnt);
            end else begin
                e = sb_q.pop_front();
                checkOutput("ser_bit", {31'd0, ser_data_o}, {31'd0, e.b});
                checkOutput("ser_bit_cycle", cycle_cnt, e.cyc);
            end
        end else begin
            checkOutput("ser_idle_zero", {31'd0, ser_data_o}, 32'd0);
        end
    end

    // Monitor on the delay line output: each bit reappears 5 cycles later.
    always @(negedge clk_i) begin
        exp_t e;
        if (dl_val[4]) begin
            if (dl_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_delayed_bit: got bit %0b, expected none at cycle %0d",
                         dl_data[4], cycle_cnt);
            end else begin
                e = dl_q.pop_front();
                checkOutput("delayed_bit", {31'd0, dl_data[4]}, {31'd0, e.b});
                checkOutput("delayed_bit_cycle", cycle_cnt, e.cyc);
            end
        end
    end

    // Offer a word and wait (bounded) until it is accepted. The expected bits
    // start either right after acceptance or right after the previous word.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] m,
                                 input logic [15:0] exp_bits, input int n,
                                 output int k);
        int budget;
        int start;
        budget = 0;
        @(negedge clk_i);
        data_i     = d;
        data_mod_i = m;
        data_val_i = 1'b1;
        #1;
        while (!ready_o && budget < 64) begin
            @(negedge clk_i);
            #1;
            budget++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got ready_o=0 for 64 cycles, expected acceptance of %h",
                     d);
            data_val_i = 1'b0;
            k = cycle_cnt;
            return;
        end
        k = cycle_cnt + 1;
        @(posedge clk_i);
        start = (k > next_free) ? k : next_free;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{b: exp_bits[15-i], cyc: start + i});
            dl_q.push_back('{b: exp_bits[15-i], cyc: start + i + 5});
        end
        next_free = start + n;
        #1;
        data_val_i = 1'b0;
    endtask

    // Offer a word for one edge while the block must refuse it.
    task automatic offerRejected(input logic [15:0] d, input logic [3:0] m);
        @(negedge clk_i);
        data_i     = d;
        data_mod_i = m;
        data_val_i = 1'b1;
        #1;
        checkOutput("ready_while_pending", {31'd0, ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        data_val_i = 1'b0;
    endtask

    task automatic waitCycle(input int c);
        while (cycle_cnt < c) @(negedge clk_i);
        #1;
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while ((busy_o || sb_q.size() != 0 || dl_q.size() != 0) && budget < 200) begin
            @(negedge clk_i);
            budget++;
        end
        #1;
        checkOutput("drain", {31'd0, (busy_o || sb_q.size() != 0 || dl_q.size() != 0)}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int kb;

        // Reset held with a word offered: nothing may be accepted.
        rst_i      = 1'b1;
        data_val_i = 1'b1;
        data_i     = 16'h1234;
        data_mod_i = 4'd0;
        repeat (2) begin
            @(negedge clk_i);
            #1;
            checkOutput("rst_ser_data", {31'd0, ser_data_o}, 32'd0);
            checkOutput("rst_ser_val", {31'd0, ser_data_val_o}, 32'd0);
            checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
            checkOutput("rst_ready", {31'd0, ready_o}, 32'd0);
        end
        @(negedge clk_i);
        rst_i      = 1'b0;
        data_val_i = 1'b0;
        #1;
        checkOutput("ready_after_release", {31'd0, ready_o}, 32'd1);
        @(negedge clk_i);
        #1;
        checkOutput("val_after_release", {31'd0, ser_data_val_o}, 32'd0);
        checkOutput("busy_after_release", {31'd0, busy_o}, 32'd0);

        // Full 16-bit word.
        applyStimulus(16'hA5F0, 4'd0, 16'b1010_0101_1111_0000, 16, k);
        waitCycle(k + 16);
        checkOutput("full_val_end", {31'd0, ser_data_val_o}, 32'd0);
        checkOutput("full_busy_end", {31'd0, busy_o}, 32'd0);
        waitDrain();

        // Short word: only the top three bits go out.
        applyStimulus(16'hE0FF, 4'd3, 16'b1110_0000_0000_0000, 3, k);
        waitCycle(k + 3);
        checkOutput("short_val_end", {31'd0, ser_data_val_o}, 32'd0);
        waitDrain();

        // Back-to-back through the pending slot; C must be refused.
        applyStimulus(16'h9000, 4'd4, 16'b1001_0000_0000_0000, 4, k);
        applyStimulus(16'h4000, 4'd2, 16'b0100_0000_0000_0000, 2, kb);
        offerRejected(16'hFFFF, 4'd0);
        waitCycle(k + 3);
        checkOutput("ready_low_pending", {31'd0, ready_o}, 32'd0);
        waitCycle(k + 4);
        checkOutput("ready_after_handoff", {31'd0, ready_o}, 32'd1);
        checkOutput("busy_after_handoff", {31'd0, busy_o}, 32'd1);
        waitDrain();

        // Same-edge handoff: next word accepted on the edge A's last bit leaves.
        applyStimulus(16'h9000, 4'd4, 16'b1001_0000_0000_0000, 4, k);
        waitCycle(k + 2);
        applyStimulus(16'h8000, 4'd1, 16'b1000_0000_0000_0000, 1, kb);
        @(negedge clk_i);
        #1;
        checkOutput("handoff_busy", {31'd0, busy_o}, 32'd1);
        checkOutput("handoff_val", {31'd0, ser_data_val_o}, 32'd1);
        waitDrain();

        // Reset in the middle of a word: outputs clear at once, nothing follows.
        applyStimulus(16'hFFFF, 4'd0, 16'hFFFF, 16, k);
        waitCycle(k + 5);
        rst_i = 1'b1;
        #1;
        checkOutput("midrst_ser_data", {31'd0, ser_data_o}, 32'd0);
        checkOutput("midrst_ser_val", {31'd0, ser_data_val_o}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy_o}, 32'd0);
        sb_q.delete();
        dl_q.delete();
        next_free = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        #1;
        checkOutput("midrst_no_resume", {31'd0, ser_data_val_o}, 32'd0);

        // Chain through the delay line: each bit reappears 5 cycles later.
        applyStimulus(16'hB2C5, 4'd0, 16'b1011_0010_1100_0101, 16, k);
        waitDrain();

        checkOutput("queues_empty", sb_q.size() + dl_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
